// File: rtl/nibble_bank_loader.sv
// Per-channel shift registers loaded LANE_W bits at a time, MSB-first,
// with full/done/overflow flags and an optional wrap-around policy.
module nibble_bank_loader #(
    parameter int LANE_W = 4,
    parameter int NUM_CH = 2,
    parameter int REG_W  = 128,
    parameter int WRAP   = 0,
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int BEATS = REG_W / LANE_W,
    localparam int CNT_W = $clog2(BEATS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    input  logic [SEL_W-1:0]         wr_sel,
    input  logic [LANE_W-1:0]        wr_data,
    input  logic [NUM_CH-1:0]        clr_mask,
    output logic [NUM_CH*REG_W-1:0]  regs,
    output logic [NUM_CH-1:0]        full,
    output logic [NUM_CH-1:0]        done,
    output logic [NUM_CH-1:0]        ovf,
    output logic [CNT_W-1:0]         sel_count
);

    logic [NUM_CH*CNT_W-1:0] cnt_flat;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [REG_W-1:0] data_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             full_reg;
            logic             done_reg;
            logic             ovf_reg;
            logic             hit;

            // Out-of-range selects never match any channel, so they are ignored.
            assign hit = wr_valid && (wr_sel == SEL_W'(gi));

            always_ff @(posedge clk) begin
                if (rst || clr_mask[gi]) begin
                    data_reg <= '0;
                    cnt_reg  <= '0;
                    full_reg <= 1'b0;
                    done_reg <= 1'b0;
                    ovf_reg  <= 1'b0;
                end else begin
                    done_reg <= 1'b0;
                    if (hit) begin
                        if (full_reg && WRAP == 0) begin
                            ovf_reg <= 1'b1;
                        end else begin
                            data_reg <= {data_reg[REG_W-LANE_W-1:0], wr_data};
                            if (full_reg) begin
                                // Wrapping: this beat starts a fresh load.
                                cnt_reg  <= CNT_W'(1);
                                full_reg <= 1'b0;
                            end else begin
                                cnt_reg <= cnt_reg + CNT_W'(1);
                                if (cnt_reg == CNT_W'(BEATS - 1)) begin
                                    full_reg <= 1'b1;
                                    done_reg <= 1'b1;
                                end
                            end
                        end
                    end
                end
            end

            assign regs[gi*REG_W +: REG_W]     = data_reg;
            assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_reg;
            assign full[gi]                    = full_reg;
            assign done[gi]                    = done_reg;
            assign ovf[gi]                     = ovf_reg;
        end
    endgenerate

    always_comb begin
        sel_count = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (wr_sel == SEL_W'(k)) begin
                sel_count = cnt_flat[k*CNT_W +: CNT_W];
            end
        end
    end

endmodule

// File: doc/nibble_bank_loader.md
NIBBLE_BANK_LOADER -- requirements
Module: nibble_bank_loader

Interface
REQ-001 SHALL have parameter LANE_W, default 4: bits accepted per write beat.
REQ-002 SHALL have parameter NUM_CH, default 2: number of independent channel registers.
REQ-003 SHALL have parameter REG_W, default 128: width of each channel register; an integer multiple of LANE_W, with REG_W/LANE_W >= 2.
REQ-004 SHALL have parameter WRAP, default 0: full-channel policy; 0 = drop writes, 1 = keep shifting.
REQ-005 SHALL derive localparams SEL_W = max(1, clog2(NUM_CH)), BEATS = REG_W/LANE_W, CNT_W = clog2(BEATS+1).
REQ-006 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port wr_valid, input, 1: write beat present.
REQ-009 SHALL have port wr_sel, input, SEL_W: target channel of the write beat.
REQ-010 SHALL have port wr_data, input, LANE_W: write beat payload.
REQ-011 SHALL have port clr_mask, input, NUM_CH: per-channel clear request.
REQ-012 SHALL have port regs, output, NUM_CH*REG_W: all channel registers, flattened; channel k occupies bits [k*REG_W +: REG_W].
REQ-013 SHALL have port full, output, NUM_CH: per-channel "BEATS beats loaded" flag.
REQ-014 SHALL have port done, output, NUM_CH: one-cycle pulse per channel as that channel becomes full.
REQ-015 SHALL have port ovf, output, NUM_CH: sticky per-channel flag for a write dropped while full.
REQ-016 SHALL have port sel_count, output, CNT_W: beat count of the channel currently addressed by wr_sel (combinational read).

Function
REQ-017 SHALL, on an accepted write to channel c, shift MSB-first: reg_c <= {reg_c[REG_W-LANE_W-1:0], wr_data}, and cnt_c <= cnt_c+1; the new value is visible on regs the following cycle.
REQ-018 SHALL accept a write when wr_valid=1, wr_sel < NUM_CH, clr_mask[wr_sel]=0, and (full[wr_sel]=0 or WRAP=1).
REQ-019 SHALL ignore wr_valid with wr_sel >= NUM_CH: no state change and no flag change.
REQ-020 SHALL, on the accepted write that takes cnt_c from BEATS-1 to BEATS, set full[c]=1 and assert done[c] for exactly the next cycle.
REQ-021 SHALL, when WRAP=0 and full[c]=1, drop a write to c: reg_c and cnt_c unchanged, ovf[c] set and held until clear or reset.
REQ-022 SHALL, when WRAP=1 and full[c]=1, still shift reg_c in the write, set cnt_c to 1 and full[c] to 0; full and done then recur after a further BEATS-1 beats; ovf[c] stays 0.
REQ-023 SHALL, for clr_mask[c]=1, next cycle set reg_c=0, cnt_c=0, full[c]=0, ovf[c]=0, done[c]=0.
REQ-024 SHALL give clear priority over a simultaneous write to the same channel; that write is discarded and does not set ovf.
REQ-025 SHALL let a write to channel c proceed normally in the same cycle as clears of other channels.
REQ-026 SHALL modify only the addressed channel on a write; all other channels hold.
REQ-027 SHALL drive sel_count as cnt of channel wr_sel, and as 0 when wr_sel >= NUM_CH.
REQ-028 SHALL implement cnt_c as a saturating counter in 0..BEATS; it never exceeds BEATS.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, set every reg_c=0, cnt_c=0, full=0, done=0, ovf=0; rst overrides a simultaneous write or clear.
REQ-030 SHALL abandon a partially loaded channel when reset is asserted mid-load; the next write after reset is counted as beat 1.
REQ-031 SHALL produce no done pulse on the cycle reset deasserts.

Verification (bench configuration: NUM_CH=2, REG_W=32, LANE_W=4, BEATS=8)
REQ-032 SHALL cover load and full: write beats 1..8 to ch0 -> regs[31:0]=0x12345678; full[0] rises after beat 8; done[0] high for 1 cycle; ch1 stays 0.
REQ-033 SHALL cover overflow with WRAP=0: after REQ-032, write 0xF to ch0 -> regs[31:0] still 0x12345678; ovf[0]=1; clr_mask=2'b01 -> reg, count and flags of ch0 =0.
REQ-034 SHALL cover wrap with WRAP=1: after 8 beats, write 0x9 to ch0 -> regs[31:0]=0x23456789, sel_count=1, full[0]=0; 7 more beats -> done[0] pulses again.
REQ-035 SHALL cover simultaneous events: clr_mask=2'b10 with a write of 0xA to ch1 -> ch1=0 and count 0; clr_mask=2'b10 with a write of 0xA to ch0 -> ch0 shifts in 0xA, ch1 cleared.
REQ-036 SHALL cover mid-load reset: 3 beats to ch1, pulse rst for 1 cycle -> all outputs 0; one beat 0x5 -> regs[63:32]=0x00000005, sel_count=1.
REQ-037 SHALL cover an invalid select: with NUM_CH=3 and wr_sel=3, wr_valid=1 -> no register or flag change; sel_count=0.
